// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 receive sequencer: scan codes,
// parser states and the packed event entry layout.
package ps2_pkg;

    // Prefix and control bytes of the set-2 grammar.
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    // Game keys tracked in key_state.
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ONE   = 8'h16;
    localparam logic [7:0] SC_TWO   = 8'h1E;
    localparam int         NUM_KEYS = 4;

    // Event entry = {extended, break, code[7:0]}.
    localparam int EVT_W        = 10;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_BRK_BIT  = 8;
    localparam int EVT_EXT_BIT  = 9;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_EXT     = 2'd1,
        P_BRK     = 2'd2,
        P_EXT_BRK = 2'd3
    } parser_state_t;

    // Scan code owning bit idx of key_state ({two, one, enter, space}).
    function automatic logic [7:0] key_code(input int idx);
        case (idx)
            0:       key_code = SC_SPACE;
            1:       key_code = SC_ENTER;
            2:       key_code = SC_ONE;
            default: key_code = SC_TWO;
        endcase
    endfunction

    function automatic logic [EVT_W-1:0] pack_event(input logic ext, input logic brk,
                                                    input logic [7:0] code);
        pack_event = {ext, brk, code};
    endfunction

endpackage

// File: rtl/ps2_rx_sequencer_if.sv
// Receiver-side byte strobe and event-queue handshake bundle.
// master = the sequencer, slave = receiver/consumer side.
interface ps2_rx_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_data_en;
    logic       wait_for_incoming_data;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_break;

    modport master (
        input  rx_data, rx_data_en, event_ready,
        output wait_for_incoming_data, event_valid, event_code,
               event_extended, event_break
    );

    modport slave (
        output rx_data, rx_data_en, event_ready,
        input  wait_for_incoming_data, event_valid, event_code,
               event_extended, event_break
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO for key events. The head entry is read
// combinationally so a push is visible right after its edge; an empty
// FIFO presents zeros rather than stale storage.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; no reset needed since empty masks the output.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/ps2_rx_sequencer.sv
// PS/2 set-2 receive sequencer: parses E0/F0 prefixes into key events,
// queues them in a FWFT FIFO and tracks held state of four game keys.
module ps2_rx_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    ps2_rx_sequencer_if.master     bus,
    output logic [NUM_KEYS-1:0]    key_state,
    output logic                   sequence_error,
    output logic                   overflow,
    input  logic                   clear_overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    parser_state_t      state_reg, state_next;
    parser_state_t      eff_state;
    logic [TW-1:0]      timeout_reg;
    logic               seq_err_reg, seq_err_next;
    logic               wait_reg;
    logic               overflow_reg;
    logic [NUM_KEYS-1:0] key_state_reg;

    logic               byte_en;
    logic [7:0]         rx_byte;
    logic               emit;
    logic               emit_ext;
    logic               emit_brk;
    logic               unexpected;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [EVT_W-1:0]   fifo_dout;

    assign byte_en = enable & bus.rx_data_en;
    assign rx_byte = bus.rx_data;

    // State register for the prefix parser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= P_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and emit decode; an unexpected prefix is reported and then
    // reinterpreted from idle so the new sequence is not lost.
    always_comb begin
        state_next   = state_reg;
        eff_state    = state_reg;
        emit         = 1'b0;
        emit_ext     = 1'b0;
        emit_brk     = 1'b0;
        seq_err_next = 1'b0;
        unexpected   = 1'b0;
        if (!enable) begin
            state_next = P_IDLE;
        end else if (byte_en) begin
            if (rx_byte == SC_00 || rx_byte == SC_FF) begin
                seq_err_next = 1'b1;
                state_next   = P_IDLE;
            end else begin
                unexpected = ((rx_byte == SC_E0) && (state_reg != P_IDLE)) ||
                             ((rx_byte == SC_F0) &&
                              (state_reg == P_BRK || state_reg == P_EXT_BRK));
                if (unexpected) begin
                    seq_err_next = 1'b1;
                    eff_state    = P_IDLE;
                end
                case (eff_state)
                    P_IDLE: begin
                        if (rx_byte == SC_E0)      state_next = P_EXT;
                        else if (rx_byte == SC_F0) state_next = P_BRK;
                        else begin
                            state_next = P_IDLE;
                            emit = !(rx_byte == SC_AA || rx_byte == SC_FA ||
                                     rx_byte == SC_EE);
                        end
                    end
                    P_EXT: begin
                        if (rx_byte == SC_F0) state_next = P_EXT_BRK;
                        else begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            state_next = P_IDLE;
                        end
                    end
                    P_BRK: begin
                        emit       = 1'b1;
                        emit_brk   = 1'b1;
                        state_next = P_IDLE;
                    end
                    default: begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_brk   = 1'b1;
                        state_next = P_IDLE;
                    end
                endcase
            end
        end else if (state_reg != P_IDLE && timeout_reg == TIMEOUT_LAST) begin
            seq_err_next = 1'b1;
            state_next   = P_IDLE;
        end
    end

    // Saturating idle counter, live only while a prefix is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_reg <= '0;
        end else if (!enable || byte_en || state_reg == P_IDLE) begin
            timeout_reg <= '0;
        end else if (timeout_reg != TIMEOUT_LAST) begin
            timeout_reg <= timeout_reg + 1'b1;
        end
    end

    // Registered status: one-cycle error pulse, receiver arm, sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_err_reg  <= 1'b0;
            wait_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            seq_err_reg <= seq_err_next;
            wait_reg    <= enable & ~fifo_full;
            if (emit && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
            else if (clear_overflow)            overflow_reg <= 1'b0;
        end
    end

    // One tracker per game key; extended codes never alias the plain keys.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            // Make sets, break clears, on the emitting edge.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    key_state_reg[gi] <= 1'b0;
                end else if (emit && !emit_ext && rx_byte == key_code(gi)) begin
                    key_state_reg[gi] <= ~emit_brk;
                end
            end
        end
    endgenerate

    assign fifo_pop = bus.event_ready & ~fifo_empty;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (emit),
        .din   (pack_event(emit_ext, emit_brk, rx_byte)),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.wait_for_incoming_data = wait_reg;
    assign bus.event_valid            = ~fifo_empty;
    assign bus.event_code             = fifo_dout[EVT_CODE_LSB +: 8];
    assign bus.event_extended         = fifo_dout[EVT_EXT_BIT];
    assign bus.event_break            = fifo_dout[EVT_BRK_BIT];
    assign key_state                  = key_state_reg;
    assign sequence_error             = seq_err_reg;
    assign overflow                   = overflow_reg;
endmodule

// File: doc/ps2_rx_sequencer.md
# ps2_rx_sequencer

Controller that sits between the PS/2 receive datapath and the game logic. It arms the receiver by driving its wait-for-data request and consumes each received byte. It parses the PS/2 set-2 prefix grammar (0xE0 extended, 0xF0 break) into whole key events, buffers those events in a small FIFO with a valid/ready handshake, and maintains a level key-state vector for the four game keys.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: idle clk cycles allowed after a prefix byte before the partial sequence is abandoned (1 ms at 50 MHz).

- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  1 = sequencer active.
- rx_data  in  8  byte from the receiver, valid when rx_data_en=1.
- rx_data_en  in  1  one-cycle strobe from the receiver: new byte.
- wait_for_incoming_data  out  1  to the receiver; 1 = arm for the next frame.
- event_valid  out  1  FIFO not empty.
- event_ready  in  1  consumer pops the head entry when valid&ready.
- event_code  out  8  scan code of the head event.
- event_extended  out  1  head event was E0-prefixed.
- event_break  out  1  head event is a release (F0-prefixed).
- key_state  out  4  {two, one, enter, space}; 1 = held.
- sequence_error  out  1  one-cycle pulse: malformed or timed-out sequence.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.

## Operation
- Reset values: wait_for_incoming_data=0, event_valid=0, event_code=0, event_extended=0, event_break=0, key_state=0, sequence_error=0, overflow=0. Parser is in P_IDLE, FIFO is empty, and the timeout counter is 0.
- wait_for_incoming_data = registered (enable & !fifo_full).
- Parser states: P_IDLE, P_EXT (E0 seen), P_BRK (F0 seen), P_EXT_BRK (E0 F0 seen). Each byte is processed in the cycle rx_data_en=1.
  - P_IDLE: E0→P_EXT; F0→P_BRK; 0xAA, 0xFA, 0xEE discarded (no event); 0x00 or 0xFF → sequence_error, stay; any other byte → emit {ext=0, brk=0}.
  - P_EXT: F0→P_EXT_BRK; other non-prefix byte → emit {ext=1, brk=0}, →P_IDLE.
  - P_BRK: non-prefix byte → emit {ext=0, brk=1}, →P_IDLE.
  - P_EXT_BRK: non-prefix byte → emit {ext=1, brk=1}, →P_IDLE.
  - Unexpected prefix (E0 in P_EXT, P_BRK or P_EXT_BRK; F0 in P_BRK or P_EXT_BRK): pulse sequence_error, then treat the byte as if received in P_IDLE.
  - 0x00 or 0xFF in any non-idle state: pulse sequence_error, →P_IDLE, no event.
- Timeout: the counter runs in non-idle states, clears on each byte, and saturates. When it reaches TIMEOUT_CYCLES-1: pulse sequence_error, →P_IDLE.
- key_state updates on emit, not on FIFO pop, and only for non-extended codes: 0x29 space, 0x5A enter, 0x16 one, 0x1E two. Make sets the bit, break clears it. Extended codes never touch key_state.
- FIFO:
  - First-word-fall-through; entry = {extended, break, code[7:0]}.
  - Push when full without a simultaneous pop: entry dropped, overflow←1.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Pop when empty: ignored.
- enable=0: parser forced to P_IDLE and the timeout counter cleared synchronously. Bytes are ignored. FIFO contents and key_state are held, and pops still work.
- clear_overflow together with a new overflow event in the same cycle: the set wins.

## Timing
- rx_data_en at edge N → event visible (event_valid=1 when the FIFO was empty) after edge N; latency 1 cycle.
- key_state and the parser state update at the same edge N.
- sequence_error is registered and high for exactly one cycle after the causing edge.
- A pop at edge M: the next head appears after edge M, or event_valid falls.
- wait_for_incoming_data lags enable and fifo_full by 1 cycle. A frame already in flight when it drops still completes and may overflow.
- Asynchronous reset assertion mid-sequence clears all state immediately; deassertion is synchronized externally.

## Structure
- Package ps2_pkg:
  - scan-code constants: E0, F0, AA, FA, EE, 29, 5A, 16, 1E.
  - parser state enum.
  - event entry width (10) and field offsets.
- Sub-module ps2_event_fifo: parameterized depth/width, FWFT, full/empty flags, push/pop.
- The parser FSM, timeout counter and key_state logic live in ps2_rx_sequencer.

## Test plan
- Bytes 29, F0 29 with event_ready=1: events {0,0,29} then {0,1,29}; key_state[0] goes 1 then 0.
- Bytes E0 F0 75: one event {1,1,75}; no key_state change; no error.
- E0 followed by silence for TIMEOUT_CYCLES: sequence_error pulse; a following 5A emits {0,0,5A} and sets enter.
- FIFO_DEPTH+1 makes with event_ready=0: FIFO full, wait_for_incoming_data=0, overflow=1, first FIFO_DEPTH codes preserved in order. clear_overflow then clears the flag.
- Push and pop in the same cycle while full: occupancy unchanged, overflow stays 0.
- Reset asserted between F0 and 16: all outputs 0, parser in P_IDLE. A following 16 is a make and sets one.
